flag_register_unit: RTL and testbench



---
 rtl/flag_register_unit_pkg.sv | 36 +++
 rtl/flag_register_unit_calc.sv | 19 +
 rtl/flag_register_unit.sv | 93 +++++++++
 tb/tb_flag_register_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/flag_register_unit_pkg.sv
// Shared opcode encodings, flag bit positions and the per-opcode flag write mask.
package flag_register_unit_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OPC_W-1:0] OP_XOR = 4'b0010;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0011;
  localparam logic [OPC_W-1:0] OP_SLL = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SRA = 4'b0101;
  localparam logic [OPC_W-1:0] OP_ROR = 4'b0110;
  localparam logic [OPC_W-1:0] OP_LW  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_SW  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_LI  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_B   = 4'b1010;
  localparam logic [OPC_W-1:0] OP_BR  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [2:0] CCC_UNCOND = 3'b111;

  // Write mask in {Z,V,N} order; zero means the opcode leaves the flags alone.
  function automatic logic [2:0] op_flag_mask(input logic [OPC_W-1:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB:         op_flag_mask = 3'b111;
      OP_XOR, OP_SLL,
      OP_SRA, OP_ROR:         op_flag_mask = 3'b100;
      default:                op_flag_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/flag_register_unit_calc.sv
// Combinational Z/V/N derivation from an ALU result and its overflow bit.
module flag_calc
  import flag_register_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovfl,
  output logic [2:0]        zvn
);

  always_comb begin
    zvn         = 3'b000;
    zvn[FLAG_Z] = (alu_result == '0);
    zvn[FLAG_V] = alu_ovfl;
    zvn[FLAG_N] = alu_result[DATA_W-1];
  end

endmodule

// File: rtl/flag_register_unit.sv
// Condition flag producer: EX capture into a pending stage, masked commit to the
// architectural flags, newest-flags bypass and branch-on-flags hazard detect.
module flag_register_unit
  import flag_register_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovfl,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_is_branch,
  input  logic [2:0]        id_ccc,
  output logic [2:0]        flags,
  output logic [2:0]        flags_fwd,
  output logic              flag_hazard
);

  logic [2:0] flags_q, flags_d;
  logic       pend_valid_q, pend_valid_d;
  logic [2:0] pend_mask_q, pend_mask_d;
  logic [2:0] pend_val_q, pend_val_d;

  logic [2:0] ex_zvn;
  logic [2:0] ex_mask;
  logic       ex_sets;
  logic       capture;
  logic       commit;

  flag_calc #(.DATA_W(DATA_W)) u_flag_calc (
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .zvn        (ex_zvn)
  );

  assign ex_mask = op_flag_mask(ex_opcode);
  assign ex_sets = ex_valid && (ex_mask != 3'b000);
  assign capture = ex_sets && !stall && !flush;
  // Flush drops the pending update rather than retiring it.
  assign commit  = pend_valid_q && !stall && !flush;

  always_comb begin
    flags_d      = flags_q;
    pend_valid_d = pend_valid_q;
    pend_mask_d  = pend_mask_q;
    pend_val_d   = pend_val_q;

    if (commit) begin
      flags_d = (flags_q & ~pend_mask_q) | (pend_val_q & pend_mask_q);
    end

    if (flush) begin
      pend_valid_d = 1'b0;
      pend_mask_d  = 3'b000;
    end else if (!stall) begin
      pend_valid_d = capture;
      if (capture) begin
        pend_mask_d = ex_mask;
        pend_val_d  = ex_zvn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= 3'b000;
      pend_valid_q <= 1'b0;
      pend_mask_q  <= 3'b000;
      pend_val_q   <= 3'b000;
    end else begin
      flags_q      <= flags_d;
      pend_valid_q <= pend_valid_d;
      pend_mask_q  <= pend_mask_d;
      pend_val_q   <= pend_val_d;
    end
  end

  always_comb begin
    flags_fwd = flags_q;
    for (int i = 0; i < 3; i++) begin
      if (pend_valid_q && pend_mask_q[i]) flags_fwd[i] = pend_val_q[i];
    end
  end

  assign flags       = flags_q;
  assign flag_hazard = id_is_branch && (id_ccc != CCC_UNCOND) && ex_sets && !flush;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed bench for flag_register_unit with hand-computed expected flags.
module tb_flag_register_unit;
  import flag_register_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        id_is_branch;
  logic [2:0]  id_ccc;
  logic [2:0]  flags;
  logic [2:0]  flags_fwd;
  logic        flag_hazard;

  int n_checks = 0;
  int n_errors = 0;

  flag_register_unit #(.DATA_W(16), .OP_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .alu_result   (alu_result),
    .alu_ovfl     (alu_ovfl),
    .stall        (stall),
    .flush        (flush),
    .id_is_branch (id_is_branch),
    .id_ccc       (id_ccc),
    .flags        (flags),
    .flags_fwd    (flags_fwd),
    .flag_hazard  (flag_hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [3:0] op, input logic [15:0] res, input logic ov);
    ex_valid   = v;
    ex_opcode  = op;
    alu_result = res;
    alu_ovfl   = ov;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_is_branch = 1'b0; id_ccc = 3'b000;
    ex(1'b0, OP_LW, 16'h0000, 1'b0);
    step(); step();
    rst = 1'b0;
    check("rst_flags", flags, 3'b000);
    check("rst_fwd", flags_fwd, 3'b000);
    check("rst_hazard", {2'b00, flag_hazard}, 3'b000);

    // ADD zero with overflow: Z=1 V=1 N=0
    ex(1'b1, OP_ADD, 16'h0000, 1'b1);
    step();
    ex(1'b0, OP_LW, 16'h0000, 1'b0);
    check("add_e1_fwd", flags_fwd, 3'b110);
    check("add_e1_flags", flags, 3'b000);
    step();
    check("add_e2_flags", flags, 3'b110);
    check("add_e2_fwd", flags_fwd, 3'b110);

    // SUB 8001 then XOR 0000 back to back
    ex(1'b1, OP_SUB, 16'h8001, 1'b0);
    step();
    ex(1'b1, OP_XOR, 16'h0000, 1'b0);
    step();
    ex(1'b0, OP_LW, 16'h0000, 1'b0);
    check("b2b_flags_sub", flags, 3'b001);
    check("b2b_fwd_xor", flags_fwd, 3'b101);
    step();
    check("b2b_flags_xor", flags, 3'b101);

    // Hazard detection (combinational)
    ex(1'b1, OP_ADD, 16'h0005, 1'b0);
    id_is_branch = 1'b1; id_ccc = 3'b001;
    #1 check("haz_cond", {2'b00, flag_hazard}, 3'b001);
    id_ccc = CCC_UNCOND;
    #1 check("haz_uncond", {2'b00, flag_hazard}, 3'b000);
    id_ccc = 3'b001; ex_opcode = OP_LW;
    #1 check("haz_lw", {2'b00, flag_hazard}, 3'b000);
    ex_opcode = OP_ROR;
    #1 check("haz_ror", {2'b00, flag_hazard}, 3'b001);
    flush = 1'b1;
    #1 check("haz_flush", {2'b00, flag_hazard}, 3'b000);
    flush = 1'b0; id_is_branch = 1'b0;
    ex(1'b0, OP_LW, 16'h0000, 1'b0);

    // SUB FFFF captured then 3-cycle stall
    ex(1'b1, OP_SUB, 16'hFFFF, 1'b0);
    step();
    ex(1'b1, OP_ADD, 16'h0000, 1'b1);
    stall = 1'b1;
    check("stall_fwd0", flags_fwd, 3'b001);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_flags", flags, 3'b101);
      check("stall_fwd", flags_fwd, 3'b001);
    end
    stall = 1'b0;
    ex(1'b0, OP_LW, 16'h0000, 1'b0);
    step();
    check("unstall_flags", flags, 3'b001);
    check("unstall_fwd", flags_fwd, 3'b001);

    // Flush at capture
    ex(1'b1, OP_ADD, 16'h0000, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    ex(1'b0, OP_LW, 16'h0000, 1'b0);
    check("flushcap_fwd", flags_fwd, 3'b001);
    check("flushcap_flags", flags, 3'b001);
    step();
    check("flushcap_flags2", flags, 3'b001);

    // Flush of a pending update, with stall also high
    ex(1'b1, OP_ADD, 16'h0000, 1'b1);
    step();
    ex(1'b0, OP_LW, 16'h0000, 1'b0);
    check("flushpend_fwd0", flags_fwd, 3'b110);
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    check("flushpend_fwd", flags_fwd, 3'b001);
    check("flushpend_flags", flags, 3'b001);

    // Reset while pending holds 110 under stall
    ex(1'b1, OP_ADD, 16'h0000, 1'b1);
    step();
    ex(1'b0, OP_LW, 16'h0000, 1'b0);
    stall = 1'b1;
    step();
    check("prerst_fwd", flags_fwd, 3'b110);
    check("prerst_flags", flags, 3'b001);
    rst = 1'b1;
    step();
    check("rst2_flags", flags, 3'b000);
    check("rst2_fwd", flags_fwd, 3'b000);
    check("rst2_hazard", {2'b00, flag_hazard}, 3'b000);
    rst = 1'b0; stall = 1'b0;
    step();
    check("postrst_fwd", flags_fwd, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
